// File: rtl/jstk_reader.sv
// PmodJSTK poller: periodic 5-byte SPI mode-0 exchange on ck.
// Reduces each 10-bit axis to its top nibble and returns button states.
module jstk_reader #(
    parameter int DIV     = 40,
    parameter int SS_WAIT = 800,
    parameter int GAP     = 400,
    parameter int POLL    = 1600000,
    parameter bit INV_Y   = 1'b0
) (
    input  logic       ck,
    input  logic       on,
    input  logic       miso,
    input  logic [1:0] led,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    output logic [3:0] x_joy,
    output logic [3:0] y_joy,
    output logic [2:0] btn,
    output logic       valid,
    output logic       busy
);

    localparam int CM1  = (DIV > GAP) ? DIV : GAP;
    localparam int CMAX = (SS_WAIT > CM1) ? SS_WAIT : CM1;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = $clog2(POLL + 1);

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(SS_WAIT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [PW-1:0] poll_q;
    logic [PW-1:0] poll_d;
    logic          start;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [2:0]    idx_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic [7:0]    rx_d;
    logic [1:0]    xlo_q;
    logic [1:0]    xhi_q;
    logic [1:0]    ylo_q;
    logic [1:0]    yhi_q;
    logic [2:0]    braw_q;
    logic          ss_q;
    logic          sclk_q;
    logic          mosi_q;
    logic          valid_q;
    logic          busy_q;
    logic [3:0]    x_q;
    logic [3:0]    y_q;
    logic [2:0]    btn_q;

    always_comb begin
        start  = (poll_q == POLL_LAST);
        poll_d = start ? '0 : poll_q + 1'b1;
        rx_d   = {rx_q[6:0], miso};
    end

    always_ff @(posedge ck) begin
        if (!on) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_d;
        end
    end

    always_ff @(posedge ck) begin
        if (!on) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            xlo_q   <= '0;
            xhi_q   <= '0;
            ylo_q   <= '0;
            yhi_q   <= '0;
            braw_q  <= '0;
            ss_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            x_q     <= 4'd8;
            y_q     <= 4'd8;
            btn_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    ss_q   <= 1'b1;
                    sclk_q <= 1'b0;
                    if (start) begin
                        state_q <= S_SETUP;
                        ss_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        tx_q    <= {6'b100000, led};
                        mosi_q  <= 1'b1;
                    end
                end
                S_SETUP: begin
                    mosi_q <= tx_q[7];
                    // leaving SETUP is itself the first rising SCLK edge
                    if (cnt_q == WAIT_LAST) begin
                        state_q <= S_SHIFT;
                        sclk_q  <= 1'b1;
                        rx_q    <= rx_d;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (!sclk_q) begin
                            rx_q <= rx_d;
                        end else begin
                            tx_q   <= {tx_q[6:0], 1'b0};
                            mosi_q <= tx_q[6];
                            bit_q  <= bit_q + 1'b1;
                            if (bit_q == 3'd7) begin
                                unique case (1'b1)
                                    (idx_q == 3'd0): xlo_q  <= rx_q[7:6];
                                    (idx_q == 3'd1): xhi_q  <= rx_q[1:0];
                                    (idx_q == 3'd2): ylo_q  <= rx_q[7:6];
                                    (idx_q == 3'd3): yhi_q  <= rx_q[1:0];
                                    default:         braw_q <= rx_q[2:0];
                                endcase
                                state_q <= (idx_q == 3'd4) ? S_DONE : S_GAP;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= S_SHIFT;
                        sclk_q  <= 1'b1;
                        rx_q    <= rx_d;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        idx_q   <= idx_q + 1'b1;
                        tx_q    <= 8'h00;
                        mosi_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    x_q     <= {xhi_q, xlo_q};
                    y_q     <= INV_Y ? ~{yhi_q, ylo_q} : {yhi_q, ylo_q};
                    btn_q   <= braw_q;
                    valid_q <= 1'b1;
                    ss_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ss    = ss_q;
    assign sclk  = sclk_q;
    assign mosi  = mosi_q;
    assign x_joy = x_q;
    assign y_joy = y_q;
    assign btn   = btn_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_jstk_reader.sv
// Directed bench for jstk_reader with a behavioural PmodJSTK slave.
// Two instances share inputs: plain Y and inverted Y.
module tb_jstk_reader;

    localparam int DIV     = 2;
    localparam int SS_WAIT = 4;
    localparam int GAP     = 4;
    localparam int POLL    = 400;

    logic       ck   = 1'b0;
    logic       on   = 1'b0;
    logic       miso = 1'b0;
    logic [1:0] led  = 2'b00;

    logic       ss, sclk, mosi, valid, busy;
    logic [3:0] x_joy, y_joy;
    logic [2:0] btn;
    logic       ss_n, sclk_n, mosi_n, valid_n, busy_n;
    logic [3:0] x_n, y_n;
    logic [2:0] btn_n;

    jstk_reader #(
        .DIV(DIV), .SS_WAIT(SS_WAIT), .GAP(GAP), .POLL(POLL), .INV_Y(1'b0)
    ) u_dut (
        .ck(ck), .on(on), .miso(miso), .led(led),
        .ss(ss), .sclk(sclk), .mosi(mosi),
        .x_joy(x_joy), .y_joy(y_joy), .btn(btn),
        .valid(valid), .busy(busy)
    );

    jstk_reader #(
        .DIV(DIV), .SS_WAIT(SS_WAIT), .GAP(GAP), .POLL(POLL), .INV_Y(1'b1)
    ) u_inv (
        .ck(ck), .on(on), .miso(miso), .led(led),
        .ss(ss_n), .sclk(sclk_n), .mosi(mosi_n),
        .x_joy(x_n), .y_joy(y_n), .btn(btn_n),
        .valid(valid_n), .busy(busy_n)
    );

    always #5 ck = ~ck;

    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    logic [7:0] slv [5];
    logic [7:0] cap [5];
    logic [7:0] sout = 8'h00;
    logic [7:0] sin  = 8'h00;
    int  sbyte = 0, sbit = 0;
    logic ss_p = 1'b1, sclk_p = 1'b0;
    int  sfall_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    int  rises = 0, falls = 0, first_rise = 0;
    int  hi_bad = 0, lo_bad = 0, min_gap = 0;
    int  vcount = 0, vcyc = 0, prev_vcyc = 0;
    bit  ss_rise_ok = 1'b0;

    // slave model and edge monitor, sampled away from the ck rising edge
    always @(negedge ck) begin
        if (ss_p && !ss) begin
            sfall_cyc = cyc;
            rises = 0; falls = 0; hi_bad = 0; lo_bad = 0;
            min_gap = 9999; first_rise = -1;
            sbyte = 0; sbit = 0;
            sout = slv[0];
            miso = sout[7];
        end else if (!ss) begin
            if (!sclk_p && sclk) begin
                sin = {sin[6:0], mosi};
                if (rises == 0) first_rise = cyc - sfall_cyc;
                else if (rises % 8 == 0) begin
                    if (cyc - fall_cyc < min_gap) min_gap = cyc - fall_cyc;
                end else if (cyc - fall_cyc != DIV) lo_bad++;
                rises++;
                rise_cyc = cyc;
            end
            if (sclk_p && !sclk) begin
                if (cyc - rise_cyc != DIV) hi_bad++;
                falls++;
                fall_cyc = cyc;
                sbit++;
                if (sbit == 8) begin
                    if (sbyte < 5) cap[sbyte] = sin;
                    sbyte++;
                    sbit = 0;
                    sout = (sbyte < 5) ? slv[sbyte] : 8'h00;
                end else begin
                    sout = {sout[6:0], 1'b0};
                end
                miso = sout[7];
            end
        end
        if (!ss_p && ss)
            ss_rise_ok = (falls == 40) && !sclk && (cyc > fall_cyc);
        if (valid) begin
            prev_vcyc = vcyc;
            vcyc = cyc;
            vcount++;
        end
        ss_p = ss;
        sclk_p = sclk;
    end

    int errors = 0;
    int checks = 0;
    int rel = 0;
    int vsave = 0;

    task automatic tick();
        @(negedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3,
                        input logic [7:0] b4);
        slv[0] = b0; slv[1] = b1; slv[2] = b2; slv[3] = b3; slv[4] = b4;
    endtask

    task automatic wait_ss_fall(input string tag);
        int n = 0;
        while (ss !== 1'b0 && n < 500) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, ss}, 32'd0);
    endtask

    task automatic check_txn(input string tag, input logic [3:0] ex,
                             input logic [3:0] ey, input logic [3:0] eyi,
                             input logic [2:0] eb, input logic [7:0] ec0,
                             input bit spacing, input int bound);
        int n = 0;
        while (valid !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
        chk({tag, "_x"}, {28'd0, x_joy}, {28'd0, ex});
        chk({tag, "_y"}, {28'd0, y_joy}, {28'd0, ey});
        chk({tag, "_yinv"}, {28'd0, y_n}, {28'd0, eyi});
        chk({tag, "_btn"}, {29'd0, btn}, {29'd0, eb});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, "_vwidth"}, {31'd0, valid}, 32'd0);
        chk({tag, "_mosi0"}, {24'd0, cap[0]}, {24'd0, ec0});
        chk({tag, "_mosi14"}, {cap[1], cap[2], cap[3], cap[4]}, 32'd0);
        chk({tag, "_rises"}, rises, 32'd40);
        chk({tag, "_hi"}, hi_bad, 32'd0);
        chk({tag, "_lo"}, lo_bad, 32'd0);
        chk({tag, "_ss2rise"}, first_rise, 32'd4);
        chk({tag, "_gap"}, {31'd0, min_gap >= GAP}, 32'd1);
        chk({tag, "_ssrise"}, {31'd0, ss_rise_ok}, 32'd1);
        if (spacing) chk({tag, "_period"}, vcyc - prev_vcyc, POLL);
    endtask

    initial begin
        int n;
        on = 1'b0;
        led = 2'b01;
        load(8'h3C, 8'h02, 8'h00, 8'h03, 8'h05);
        repeat (3) tick();
        chk("rst_ss", {31'd0, ss}, 32'd1);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_x", {28'd0, x_joy}, 32'd8);
        chk("rst_y", {28'd0, y_joy}, 32'd8);
        chk("rst_yinv", {28'd0, y_n}, 32'd8);
        chk("rst_btn", {29'd0, btn}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        on = 1'b1;
        rel = cyc;
        wait_ss_fall("t0_ssfall");
        chk("t0_start", sfall_cyc - rel, POLL);
        chk("t0_busy", {31'd0, busy}, 32'd1);
        repeat (10) tick();
        led = 2'b10;
        check_txn("t0", 4'h8, 4'hC, 4'h3, 3'b101, 8'h81, 1'b0, 450);

        load(8'hC0, 8'h01, 8'hFF, 8'h00, 8'h02);
        check_txn("t1", 4'h7, 4'h3, 4'hC, 3'b010, 8'h82, 1'b1, 450);

        load(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check_txn("t2", 4'hF, 4'hF, 4'h0, 3'b111, 8'h82, 1'b1, 450);

        led = 2'b11;
        load(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_txn("t3", 4'h0, 4'h0, 4'hF, 3'b000, 8'h83, 1'b1, 450);

        load(8'h40, 8'h00, 8'h80, 8'hFE, 8'hFB);
        check_txn("t4", 4'h1, 4'hA, 4'h5, 3'b011, 8'h83, 1'b1, 450);

        load(8'h81, 8'h03, 8'h41, 8'h01, 8'h04);
        wait_ss_fall("ab_ssfall");
        n = 0;
        while (!(sbyte == 2 && sbit == 3) && n < 200) begin
            tick();
            n++;
        end
        chk("ab_reach", {31'd0, (sbyte == 2)}, 32'd1);
        vsave = vcount;
        on = 1'b0;
        tick();
        chk("ab_ss", {31'd0, ss}, 32'd1);
        chk("ab_sclk", {31'd0, sclk}, 32'd0);
        chk("ab_x", {28'd0, x_joy}, 32'd8);
        chk("ab_y", {28'd0, y_joy}, 32'd8);
        chk("ab_btn", {29'd0, btn}, 32'd0);
        chk("ab_valid", {31'd0, valid}, 32'd0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        tick();
        on = 1'b1;
        rel = cyc;
        check_txn("t5", 4'hE, 4'h5, 4'hA, 3'b100, 8'h83, 1'b0, 700);
        chk("t5_start", sfall_cyc - rel, POLL);
        chk("ab_novalid", vcount, vsave + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
